// File: rtl/axi_window_bridge.sv
// AXI4 window bridge: forwards in-window bursts to the SoC RAM bus with address
// truncation and ID zero-extension; answers out-of-window bursts locally with DECERR.
module axi_window_bridge #(
   parameter int                  S_ID_W          = 4,
   parameter int                  M_ID_W          = 6,
   parameter int                  S_ADDR_W        = 32,
   parameter int                  M_ADDR_W        = 30,
   parameter int                  DATA_W          = 64,
   parameter logic [S_ADDR_W-1:0] BASE            = 32'h8000_0000,
   parameter int                  MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // slave AW
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [S_ADDR_W-1:0]   s_awaddr,
   input  logic [S_ID_W-1:0]     s_awid,
   input  logic [7:0]            s_awlen,
   input  logic [2:0]            s_awsize,
   input  logic [1:0]            s_awburst,
   input  logic                  s_awlock,
   input  logic [3:0]            s_awcache,
   input  logic [2:0]            s_awprot,
   input  logic [3:0]            s_awqos,
   // slave AR
   input  logic                  s_arvalid,
   output logic                  s_arready,
   input  logic [S_ADDR_W-1:0]   s_araddr,
   input  logic [S_ID_W-1:0]     s_arid,
   input  logic [7:0]            s_arlen,
   input  logic [2:0]            s_arsize,
   input  logic [1:0]            s_arburst,
   input  logic                  s_arlock,
   input  logic [3:0]            s_arcache,
   input  logic [2:0]            s_arprot,
   input  logic [3:0]            s_arqos,
   // slave W
   input  logic                  s_wvalid,
   output logic                  s_wready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wlast,
   // slave B
   output logic                  s_bvalid,
   input  logic                  s_bready,
   output logic [S_ID_W-1:0]     s_bid,
   output logic [1:0]            s_bresp,
   // slave R
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [S_ID_W-1:0]     s_rid,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rlast,
   // master AW
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [M_ADDR_W-1:0]   m_awaddr,
   output logic [M_ID_W-1:0]     m_awid,
   output logic [7:0]            m_awlen,
   output logic [2:0]            m_awsize,
   output logic [1:0]            m_awburst,
   output logic                  m_awlock,
   output logic [3:0]            m_awcache,
   output logic [2:0]            m_awprot,
   output logic [3:0]            m_awqos,
   // master AR
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [M_ADDR_W-1:0]   m_araddr,
   output logic [M_ID_W-1:0]     m_arid,
   output logic [7:0]            m_arlen,
   output logic [2:0]            m_arsize,
   output logic [1:0]            m_arburst,
   output logic                  m_arlock,
   output logic [3:0]            m_arcache,
   output logic [2:0]            m_arprot,
   output logic [3:0]            m_arqos,
   // master W
   output logic                  m_wvalid,
   input  logic                  m_wready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wlast,
   // master B
   input  logic                  m_bvalid,
   output logic                  m_bready,
   input  logic [M_ID_W-1:0]     m_bid,
   input  logic [1:0]            m_bresp,
   // master R
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [M_ID_W-1:0]     m_rid,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rlast
);

   localparam int             CW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0]  MAX_C = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {R_FWD, R_DRAIN, R_ERR}          r_state_t;
   typedef enum logic [1:0] {W_FWD, W_DRAIN, W_SINK, W_RESP} w_state_t;

   r_state_t             r_state_q, r_state_d;
   w_state_t             w_state_q, w_state_d;
   logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]        w_pend_q, w_pend_d;
   logic [S_ID_W-1:0]    r_id_q, r_id_d;
   logic [7:0]           r_len_q, r_len_d;
   logic [7:0]           r_beat_q, r_beat_d;
   logic [S_ID_W-1:0]    w_id_q, w_id_d;

   logic ar_in_win, aw_in_win;
   logic r_last_beat, w_open, local_b;

   assign ar_in_win = (s_araddr[S_ADDR_W-1:M_ADDR_W] == BASE[S_ADDR_W-1:M_ADDR_W]);
   assign aw_in_win = (s_awaddr[S_ADDR_W-1:M_ADDR_W] == BASE[S_ADDR_W-1:M_ADDR_W]);

   // Address-channel payload mirrors the slave side unconditionally; only valid is gated.
   assign m_araddr  = s_araddr[M_ADDR_W-1:0];
   assign m_arid    = M_ID_W'(s_arid);
   assign m_arlen   = s_arlen;
   assign m_arsize  = s_arsize;
   assign m_arburst = s_arburst;
   assign m_arlock  = s_arlock;
   assign m_arcache = s_arcache;
   assign m_arprot  = s_arprot;
   assign m_arqos   = s_arqos;

   assign m_awaddr  = s_awaddr[M_ADDR_W-1:0];
   assign m_awid    = M_ID_W'(s_awid);
   assign m_awlen   = s_awlen;
   assign m_awsize  = s_awsize;
   assign m_awburst = s_awburst;
   assign m_awlock  = s_awlock;
   assign m_awcache = s_awcache;
   assign m_awprot  = s_awprot;
   assign m_awqos   = s_awqos;

   assign m_wdata   = s_wdata;
   assign m_wstrb   = s_wstrb;
   assign m_wlast   = s_wlast;

   assign r_last_beat = (r_beat_q == r_len_q);
   assign w_open      = (w_pend_q != '0);

   // ---------------- read path ----------------
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_beat_d  = r_beat_q;
      m_arvalid = 1'b0;
      s_arready = 1'b0;
      s_rvalid  = m_rvalid;
      s_rid     = m_rid[S_ID_W-1:0];
      s_rdata   = m_rdata;
      s_rresp   = m_rresp;
      s_rlast   = m_rlast;
      m_rready  = s_rready;
      case (r_state_q)
         R_FWD: begin
            if (ar_in_win) begin
               m_arvalid = s_arvalid && (rd_cnt_q < MAX_C);
               s_arready = m_arready && (rd_cnt_q < MAX_C);
            end else begin
               s_arready = 1'b1;
               if (s_arvalid) begin
                  r_id_d    = s_arid;
                  r_len_d   = s_arlen;
                  r_beat_d  = '0;
                  r_state_d = R_DRAIN;
               end
            end
         end
         R_DRAIN: if (rd_cnt_q == '0) r_state_d = R_ERR;
         R_ERR: begin
            s_rvalid = 1'b1;
            s_rid    = r_id_q;
            s_rdata  = '0;
            s_rresp  = 2'b11;
            s_rlast  = r_last_beat;
            m_rready = 1'b0;
            if (s_rready) begin
               r_beat_d = r_beat_q + 8'd1;
               if (r_last_beat) r_state_d = R_FWD;
            end
         end
         default: r_state_d = R_FWD;
      endcase
      if (rst) begin
         m_arvalid = 1'b0;
         s_arready = 1'b0;
         s_rvalid  = 1'b0;
         m_rready  = 1'b0;
      end
   end

   always_comb begin
      rd_cnt_d = rd_cnt_q + CW'(m_arvalid && m_arready)
                          - CW'(m_rvalid && m_rready && m_rlast);
   end

   // ---------------- write path ----------------
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      m_awvalid = 1'b0;
      s_awready = 1'b0;
      m_wvalid  = 1'b0;
      s_wready  = 1'b0;
      local_b   = 1'b0;
      case (w_state_q)
         W_FWD: begin
            if (aw_in_win) begin
               m_awvalid = s_awvalid && (wr_cnt_q < MAX_C);
               s_awready = m_awready && (wr_cnt_q < MAX_C);
            end else begin
               s_awready = 1'b1;
               if (s_awvalid) begin
                  w_id_d    = s_awid;
                  w_state_d = W_DRAIN;
               end
            end
         end
         W_DRAIN: if (!w_open) w_state_d = W_SINK;
         W_SINK: begin
            s_wready = 1'b1;
            if (s_wvalid && s_wlast) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (wr_cnt_q == '0) begin
               local_b = 1'b1;
               if (s_bready) w_state_d = W_FWD;
            end
         end
         default: w_state_d = W_FWD;
      endcase
      // W data is only routed to the master once its AW has gone out.
      if (w_state_q == W_FWD || w_state_q == W_DRAIN) begin
         m_wvalid = s_wvalid && w_open;
         s_wready = m_wready && w_open;
      end
      if (local_b) begin
         s_bvalid = 1'b1;
         s_bid    = w_id_q;
         s_bresp  = 2'b11;
         m_bready = 1'b0;
      end else begin
         s_bvalid = m_bvalid;
         s_bid    = m_bid[S_ID_W-1:0];
         s_bresp  = m_bresp;
         m_bready = s_bready;
      end
      if (rst) begin
         m_awvalid = 1'b0;
         s_awready = 1'b0;
         m_wvalid  = 1'b0;
         s_wready  = 1'b0;
         s_bvalid  = 1'b0;
         m_bready  = 1'b0;
      end
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q + CW'(m_awvalid && m_awready) - CW'(m_bvalid && m_bready);
      w_pend_d = w_pend_q + CW'(m_awvalid && m_awready)
                          - CW'(m_wvalid && m_wready && s_wlast);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_FWD;
         w_state_q <= W_FWD;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         w_pend_q  <= '0;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_beat_q  <= '0;
         w_id_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         w_pend_q  <= w_pend_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_beat_q  <= r_beat_d;
         w_id_q    <= w_id_d;
      end
   end

endmodule

// File: tb/tb_axi_window_bridge.sv
// Directed bench for axi_window_bridge: forwarding, local DECERR, ordering,
// outstanding limit (MAX_OUTSTANDING=2) and mid-burst reset.
module tb_axi_window_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_awvalid = 0, s_awready;
   logic [31:0] s_awaddr = 0;
   logic [3:0]  s_awid = 0;
   logic [7:0]  s_awlen = 0;
   logic        s_arvalid = 0, s_arready;
   logic [31:0] s_araddr = 0;
   logic [3:0]  s_arid = 0;
   logic [7:0]  s_arlen = 0;
   logic        s_wvalid = 0, s_wready, s_wlast = 0;
   logic [63:0] s_wdata = 0;
   logic        s_bvalid, s_bready = 0;
   logic [3:0]  s_bid;
   logic [1:0]  s_bresp;
   logic        s_rvalid, s_rready = 0, s_rlast;
   logic [3:0]  s_rid;
   logic [63:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        m_awvalid, m_awready = 0;
   logic [29:0] m_awaddr;
   logic [5:0]  m_awid;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize, m_awprot, m_arsize, m_arprot;
   logic [1:0]  m_awburst, m_arburst;
   logic        m_awlock, m_arlock;
   logic [3:0]  m_awcache, m_awqos, m_arcache, m_arqos;
   logic        m_arvalid, m_arready = 0;
   logic [29:0] m_araddr;
   logic [5:0]  m_arid;
   logic [7:0]  m_arlen;
   logic        m_wvalid, m_wready = 0, m_wlast;
   logic [63:0] m_wdata;
   logic [7:0]  m_wstrb;
   logic        m_bvalid = 0, m_bready;
   logic [5:0]  m_bid = 0;
   logic [1:0]  m_bresp = 0;
   logic        m_rvalid = 0, m_rready, m_rlast = 0;
   logic [5:0]  m_rid = 0;
   logic [63:0] m_rdata = 0;
   logic [1:0]  m_rresp = 0;

   axi_window_bridge #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
      .s_awlen(s_awlen), .s_awsize(3'd3), .s_awburst(2'b01), .s_awlock(1'b0),
      .s_awcache(4'd0), .s_awprot(3'd0), .s_awqos(4'd0),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(3'd3), .s_arburst(2'b01), .s_arlock(1'b0),
      .s_arcache(4'd0), .s_arprot(3'd0), .s_arqos(4'd0),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(8'hff),
      .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
      .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
      .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
      .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Collect a locally generated DECERR read burst, bounded in cycles.
   task automatic collect_err(input logic [3:0] id, input int nbeats);
      int beat = 0;
      for (int c = 0; c < 40 && beat < nbeats; c++) begin
         @(negedge clk); #1;
         if (s_rvalid) begin
            chk("err_rid",   s_rid,   id);
            chk("err_rresp", s_rresp, 2'b11);
            chk("err_rdata", s_rdata, 64'd0);
            chk("err_rlast", s_rlast, beat == nbeats - 1);
            chk("err_mrrdy", m_rready, 1'b0);
            beat++;
         end
      end
      chk("err_beats", beat, nbeats);
   endtask

   task automatic mbeat(input logic [5:0] id, input logic last, input logic [3:0] exp_sid);
      @(negedge clk);
      m_rvalid = 1; m_rid = id; m_rlast = last; m_rdata = 64'hA5A5_0000 + id; s_rready = 1;
      #1;
      chk("fwd_rvalid", s_rvalid, 1'b1);
      chk("fwd_rid",    s_rid,    exp_sid);
      chk("fwd_rlast",  s_rlast,  last);
   endtask

   initial begin
      // reset state, with an out-of-window AR presented
      s_arvalid = 1; s_araddr = 32'h0;
      #1;
      chk("rst_arready", s_arready, 1'b0);
      chk("rst_awready", s_awready, 1'b0);
      chk("rst_wready",  s_wready,  1'b0);
      chk("rst_rvalid",  s_rvalid,  1'b0);
      chk("rst_bvalid",  s_bvalid,  1'b0);
      chk("rst_marvld",  m_arvalid, 1'b0);
      chk("rst_mawvld",  m_awvalid, 1'b0);
      chk("rst_mwvld",   m_wvalid,  1'b0);
      s_arvalid = 0;
      repeat (2) @(negedge clk);
      rst = 0;

      // 1: in-window read
      @(negedge clk);
      s_arvalid = 1; s_araddr = 32'h8000_1000; s_arid = 4'd3; s_arlen = 8'd3; m_arready = 1;
      #1;
      chk("t1_marvalid", m_arvalid, 1'b1);
      chk("t1_maraddr",  m_araddr,  30'h0000_1000);
      chk("t1_marid",    m_arid,    6'h03);
      chk("t1_sarready", s_arready, 1'b1);
      @(negedge clk); s_arvalid = 0;
      for (int i = 0; i < 4; i++) begin
         mbeat(6'h03, i == 3, 4'd3);
         chk("t1_rdata", s_rdata, 64'hA5A5_0003);
      end
      @(negedge clk); m_rvalid = 0; m_rlast = 0;

      // 2: out-of-window read
      @(negedge clk);
      s_arvalid = 1; s_araddr = 32'h1000_0000; s_arid = 4'd5; s_arlen = 8'd7;
      #1;
      chk("t2_marvalid", m_arvalid, 1'b0);
      chk("t2_sarready", s_arready, 1'b1);
      @(negedge clk); s_arvalid = 0; s_rready = 1;
      collect_err(4'd5, 8);
      @(negedge clk); #1;
      chk("t2_idle_rvalid", s_rvalid, 1'b0);

      // 3: ordering behind two forwarded reads
      @(negedge clk);
      s_arvalid = 1; s_araddr = 32'h8000_0100; s_arid = 4'd1; s_arlen = 0;
      #1; chk("t3_ar1", s_arready, 1'b1);
      @(negedge clk); s_arid = 4'd2;
      #1; chk("t3_ar2", s_arready, 1'b1);
      @(negedge clk); s_araddr = 32'h0000_0000; s_arid = 4'd4; s_arlen = 8'd1;
      #1; chk("t3_ar_err", s_arready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); s_araddr = 32'h8000_0200; s_arid = 4'd6; s_arlen = 0;
         #1;
         chk("t3_drain_arready", s_arready, 1'b0);
         chk("t3_drain_marvld",  m_arvalid, 1'b0);
         chk("t3_drain_rvalid",  s_rvalid,  1'b0);
      end
      s_arvalid = 0;
      mbeat(6'h01, 1'b1, 4'd1);
      chk("t3_rresp_fwd", s_rresp, 2'b00);
      mbeat(6'h02, 1'b1, 4'd2);
      @(negedge clk); m_rvalid = 0; m_rlast = 0;
      collect_err(4'd4, 2);

      // 4b: in-window write with master B
      @(negedge clk);
      s_awvalid = 1; s_awaddr = 32'h8000_0040; s_awid = 4'd2; s_awlen = 0; m_awready = 1;
      s_wvalid = 1; s_wdata = 64'h1234; s_wlast = 1; m_wready = 1;
      #1;
      chk("t4b_mawvalid", m_awvalid, 1'b1);
      chk("t4b_mawaddr",  m_awaddr,  30'h40);
      chk("t4b_mawid",    m_awid,    6'h02);
      chk("t4b_early_w",  s_wready,  1'b0);
      @(negedge clk); s_awvalid = 0;
      #1;
      chk("t4b_mwvalid", m_wvalid, 1'b1);
      chk("t4b_mwdata",  m_wdata,  64'h1234);
      chk("t4b_swready", s_wready, 1'b1);
      @(negedge clk); s_wvalid = 0; s_wlast = 0;
      m_bvalid = 1; m_bid = 6'h02; m_bresp = 2'b00; s_bready = 1;
      #1;
      chk("t4b_bvalid", s_bvalid, 1'b1);
      chk("t4b_bid",    s_bid,    4'd2);
      chk("t4b_mbrdy",  m_bready, 1'b1);
      @(negedge clk); m_bvalid = 0; s_bready = 0;

      // 4: out-of-window write
      @(negedge clk);
      s_awvalid = 1; s_awaddr = 32'h0; s_awid = 4'd9; s_awlen = 8'd3;
      #1;
      chk("t4_mawvalid", m_awvalid, 1'b0);
      chk("t4_sawready", s_awready, 1'b1);
      @(negedge clk); s_awvalid = 0;
      for (int b = 0; b < 4; b++) begin
         int waited = 0;
         s_wvalid = 1; s_wdata = 64'(b); s_wlast = (b == 3);
         #1;
         while (!s_wready && waited < 10) begin
            chk("t4_mwvalid_wait", m_wvalid, 1'b0);
            @(negedge clk); #1; waited++;
         end
         chk("t4_wready", s_wready, 1'b1);
         chk("t4_mwvalid", m_wvalid, 1'b0);
         chk("t4_no_b", s_bvalid, 1'b0);
         @(negedge clk);
      end
      s_wvalid = 0; s_wlast = 0; s_bready = 0;
      #1;
      chk("t4_bvalid", s_bvalid, 1'b1);
      chk("t4_bid",    s_bid,    4'd9);
      chk("t4_bresp",  s_bresp,  2'b11);
      @(negedge clk); #1;
      chk("t4_bhold", s_bvalid, 1'b1);
      s_bready = 1;
      @(negedge clk); s_bready = 0;
      #1;
      chk("t4_bdone", s_bvalid, 1'b0);

      // 5: outstanding limit of 2
      @(negedge clk);
      s_arvalid = 1; s_araddr = 32'h8000_0300; s_arid = 4'd1; s_arlen = 0; m_arready = 1;
      #1; chk("t5_ar1", s_arready, 1'b1);
      @(negedge clk); s_arid = 4'd2;
      #1; chk("t5_ar2", s_arready, 1'b1);
      @(negedge clk); s_arid = 4'd3;
      #1;
      chk("t5_ar3_stall",  s_arready, 1'b0);
      chk("t5_ar3_marvld", m_arvalid, 1'b0);
      @(negedge clk); #1;
      chk("t5_ar3_stall2", s_arready, 1'b0);
      mbeat(6'h01, 1'b1, 4'd1);
      chk("t5_ar3_same_cyc", s_arready, 1'b0);
      @(negedge clk); m_rvalid = 0; m_rlast = 0;
      #1;
      chk("t5_ar3_go",     s_arready, 1'b1);
      chk("t5_ar3_marvld", m_arvalid, 1'b1);
      chk("t5_ar3_marid",  m_arid,    6'h03);
      @(negedge clk); s_arvalid = 0;
      mbeat(6'h02, 1'b1, 4'd2);
      mbeat(6'h03, 1'b1, 4'd3);
      @(negedge clk); m_rvalid = 0; m_rlast = 0;

      // 6: reset during beat 2 of a local burst
      @(negedge clk);
      s_arvalid = 1; s_araddr = 32'h4000_0000; s_arid = 4'd7; s_arlen = 8'd3;
      @(negedge clk); s_arvalid = 0; s_rready = 1;
      @(negedge clk); #1;
      chk("t6_beat1", s_rvalid, 1'b1);
      @(negedge clk); #1;
      chk("t6_beat2",      s_rvalid, 1'b1);
      chk("t6_beat2_last", s_rlast,  1'b0);
      rst = 1;
      #1;
      chk("t6_rst_rvalid",  s_rvalid,  1'b0);
      chk("t6_rst_arready", s_arready, 1'b0);
      chk("t6_rst_marvld",  m_arvalid, 1'b0);
      chk("t6_rst_bvalid",  s_bvalid,  1'b0);
      @(negedge clk); rst = 0;
      @(negedge clk);
      #1; chk("t6_post_rvalid", s_rvalid, 1'b0);
      s_arvalid = 1; s_araddr = 32'h8000_2000; s_arid = 4'd2; s_arlen = 0;
      #1;
      chk("t6_marvalid", m_arvalid, 1'b1);
      chk("t6_maraddr",  m_araddr,  30'h2000);
      chk("t6_sarready", s_arready, 1'b1);
      @(negedge clk); s_arvalid = 0;
      mbeat(6'h02, 1'b1, 4'd2);
      @(negedge clk); m_rvalid = 0; m_rlast = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
